// File: rtl/add_pkg.sv
// Shared definitions for the byte-serial adder controllers: FSM states,
// slice width and the signed-overflow rule.
package add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // bMsb is the sign of the operand actually fed to the adder (after any inversion).
    function automatic logic signedOverflow(input logic aMsb,
                                            input logic bMsb,
                                            input logic rMsb);
        return (aMsb == bMsb) && (rMsb != aMsb);
    endfunction

endpackage

// File: rtl/byte_add_slice.sv
// Combinational 8-bit ripple-carry adder slice built from single-bit full adders.
module byte_add_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module byte_add_slice
    import add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              cout
);

    logic [BYTE_W:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar gi = 0; gi < BYTE_W; gi++) begin : g_fa
        byte_add_fa u_fa (
            .a    (a[gi]),
            .b    (b[gi]),
            .cin  (w_carry[gi]),
            .s    (s[gi]),
            .cout (w_carry[gi+1])
        );
    end

    assign cout = w_carry[BYTE_W];

endmodule

// File: rtl/multibyte_add_seq.sv
// Multi-precision add/subtract controller: streams operands LSB-first through
// one shared byte slice, chaining the carry through a register.
module multibyte_add_seq
    import add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [8*NBYTES-1:0]    a,
    input  logic [8*NBYTES-1:0]    b,
    output logic                   busy,
    output logic                   done,
    output logic [8*NBYTES-1:0]    sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int WIDTH = BYTE_W * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t             r_state;
    state_t             w_nextState;

    logic [WIDTH-1:0]   r_opA;
    logic [WIDTH-1:0]   r_opB;
    logic               r_sub;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic [BYTE_W-1:0]  w_aByte;
    logic [BYTE_W-1:0]  w_bByte;
    logic [BYTE_W-1:0]  w_bOp;
    logic [BYTE_W-1:0]  w_sliceSum;
    logic               w_sliceCout;
    logic               w_lastByte;

    always_comb begin
        w_aByte = '0;
        w_bByte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_aByte = r_opA[i*BYTE_W +: BYTE_W];
                w_bByte = r_opB[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Subtraction is a + ~b + 1; the +1 comes from the carry register preset to sub.
    assign w_bOp      = r_sub ? ~w_bByte : w_bByte;
    assign w_lastByte = (r_idx == LAST_IDX);

    byte_add_slice u_slice (
        .a    (w_aByte),
        .b    (w_bOp),
        .cin  (r_carry),
        .s    (w_sliceSum),
        .cout (w_sliceCout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = RUN;
            RUN:     if (w_lastByte) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Results are cleared only by an accepted start, so they stay readable after done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opA   <= '0;
            r_opB   <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_opA   <= a;
                        r_opB   <= b;
                        r_sub   <= sub;
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_sum[i*BYTE_W +: BYTE_W] <= w_sliceSum;
                        end
                    end
                    r_carry <= w_sliceCout;
                    if (w_lastByte) begin
                        r_cout <= w_sliceCout;
                        r_ovf  <= signedOverflow(w_aByte[BYTE_W-1], w_bOp[BYTE_W-1],
                                                 w_sliceSum[BYTE_W-1]);
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Self-checking bench for multibyte_add_seq (NBYTES=4): directed corner cases,
// random operands, start/operand disturbance, held start and mid-run reset.
module tb_multibyte_add_seq;

    localparam int NB = 4;

    logic            clk;
    logic            rst;
    logic            start;
    logic            sub;
    logic [31:0]     a;
    logic [31:0]     b;
    logic            busy;
    logic            done;
    logic [31:0]     sum;
    logic            cout;
    logic            ovf;

    int testCount;
    int failCount;

    multibyte_add_seq #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Plain-arithmetic reference: modular result, unsigned carry/no-borrow, signed range check.
    task automatic refModel(input logic [31:0] x, input logic [31:0] y, input logic s,
                            output logic [31:0] r, output logic c, output logic v);
        longint unsigned ux;
        longint unsigned uy;
        longint sx;
        longint sy;
        longint sr;
        ux = {32'h0, x};
        uy = {32'h0, y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!s) begin
            r  = x + y;
            c  = (ux + uy) > 64'hFFFF_FFFF;
            sr = sx + sy;
        end else begin
            r  = x - y;
            c  = (x >= y);
            sr = sx - sy;
        end
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endtask

    // Drives one operation from an idle negedge and checks every cycle until idle again.
    task automatic applyStimulus(input string tag, input logic [31:0] x, input logic [31:0] y,
                                 input logic s, input bit keepStart, input bit disturb);
        logic [31:0] expSum;
        logic        expC;
        logic        expV;
        logic [31:0] mask;
        refModel(x, y, s, expSum, expC, expV);
        a     = x;
        b     = y;
        sub   = s;
        start = 1'b1;
        for (int m = 0; m <= NB + 1; m++) begin
            @(negedge clk);
            mask = '0;
            for (int i = 0; i < NB; i++) begin
                if (i < m) mask[i*8 +: 8] = 8'hFF;
            end
            checkOutput($sformatf("%s busy c%0d", tag, m), {31'b0, busy}, 32'(m <= NB));
            checkOutput($sformatf("%s done c%0d", tag, m), {31'b0, done}, 32'(m == NB));
            checkOutput($sformatf("%s sum c%0d", tag, m), sum, expSum & mask);
            checkOutput($sformatf("%s cout c%0d", tag, m), {31'b0, cout},
                        (m >= NB) ? {31'b0, expC} : 32'h0);
            checkOutput($sformatf("%s ovf c%0d", tag, m), {31'b0, ovf},
                        (m >= NB) ? {31'b0, expV} : 32'h0);
            if (m == 0 && !keepStart) start = 1'b0;
            if (disturb) begin
                if (m == 1) begin
                    start = 1'b1;
                    a     = $urandom;
                    b     = $urandom;
                    sub   = ~s;
                end
                if (m == 2) start = 1'b0;
                if (m == 3) start = 1'b1;
                if (m == 4) start = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] rs;
        logic        rc;
        logic        rv;
        testCount = 0;
        failCount = 0;
        rst   = 1'b1;
        start = 1'b1;
        sub   = 1'b0;
        a     = 32'h1234_5678;
        b     = 32'h0000_0001;

        // Reset must win over a pending start.
        repeat (3) @(negedge clk);
        checkOutput("reset busy", {31'b0, busy}, 32'h0);
        checkOutput("reset done", {31'b0, done}, 32'h0);
        checkOutput("reset sum", sum, 32'h0);
        checkOutput("reset cout", {31'b0, cout}, 32'h0);
        checkOutput("reset ovf", {31'b0, ovf}, 32'h0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("idle busy", {31'b0, busy}, 32'h0);

        applyStimulus("ff+1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        applyStimulus("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        applyStimulus("5-7", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
        applyStimulus("min-1", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        applyStimulus("max+1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        applyStimulus("x-min", 32'h0000_0003, 32'h8000_0000, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 16; n++) begin
            applyStimulus($sformatf("rnd%0d", n), $urandom, $urandom,
                          1'($urandom_range(1)), 1'b0, 1'b0);
        end

        applyStimulus("disturb", 32'h1357_9BDF, 32'h0246_8ACE, 1'b0, 1'b0, 1'b1);

        // Held start: each return to idle immediately launches the next operation.
        applyStimulus("held1", 32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b1, 1'b0);
        applyStimulus("held2", 32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b1, 1'b0);
        applyStimulus("held3", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 1'b0);

        // Abort after two bytes are written.
        refModel(32'h0102_0304, 32'h1020_3040, 1'b0, rs, rc, rv);
        a     = 32'h0102_0304;
        b     = 32'h1020_3040;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("abort byte0", sum, rs & 32'h0000_00FF);
        @(negedge clk);
        checkOutput("abort byte1", sum, rs & 32'h0000_FFFF);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort busy", {31'b0, busy}, 32'h0);
        checkOutput("abort done", {31'b0, done}, 32'h0);
        checkOutput("abort sum", sum, 32'h0);
        checkOutput("abort cout", {31'b0, cout}, 32'h0);
        checkOutput("abort ovf", {31'b0, ovf}, 32'h0);
        rst = 1'b0;
        repeat (NB + 2) begin
            @(negedge clk);
            checkOutput("abort no done", {31'b0, done}, 32'h0);
        end
        applyStimulus("1+1", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
